// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C memory target.
package i2c_pkg;

   localparam int   I2C_MEM_DEPTH = 128;
   localparam int   I2C_PTR_W     = 7;
   localparam logic I2C_RW_READ   = 1'b1;

   // Target protocol states; exported on the debug port of the top level.
   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_DEVADDR = 4'd1,
      ST_ACK_DEV = 4'd2,
      ST_PTR     = 4'd3,
      ST_ACK_PTR = 4'd4,
      ST_WDATA   = 4'd5,
      ST_ACK_W   = 4'd6,
      ST_RDATA   = 4'd7,
      ST_MACK    = 4'd8,
      ST_IGNORE  = 4'd9
   } tgt_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises the asynchronous SCL/SDA pins into the clk domain and produces
// one-cycle event flags for SCL edges and START/STOP conditions. The flags and
// the sampled SDA level are registered together so they stay aligned, giving
// SYNC_STAGES+1 clk from pin change to flag.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_lvl
);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic scl_hist_q, scl_hist_d;
   logic sda_hist_q, sda_hist_d;
   logic scl_rise_q, scl_rise_d;
   logic scl_fall_q, scl_fall_d;
   logic start_q, start_d;
   logic stop_q, stop_d;
   logic sda_lvl_q, sda_lvl_d;
   logic scl_s, sda_s;

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   // Shift the pins through the synchronisers and compare against history.
   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_hist_d = scl_s;
      sda_hist_d = sda_s;
      scl_rise_d = scl_s & ~scl_hist_q;
      scl_fall_d = ~scl_s & scl_hist_q;
      start_d    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
      stop_d     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
      sda_lvl_d  = sda_s;
   end

   // Idle bus is high on both lines, so reset to 1 to avoid spurious events.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
         scl_rise_q <= 1'b0;
         scl_fall_q <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         sda_lvl_q  <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_hist_q <= scl_hist_d;
         sda_hist_q <= sda_hist_d;
         scl_rise_q <= scl_rise_d;
         scl_fall_q <= scl_fall_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         sda_lvl_q  <= sda_lvl_d;
      end
   end

   assign scl_rise  = scl_rise_q;
   assign scl_fall  = scl_fall_q;
   assign start_det = start_q;
   assign stop_det  = stop_q;
   assign sda_lvl   = sda_lvl_q;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with a 128x8 memory: device address match, one-byte pointer,
// auto-incrementing writes and reads, open-drain SDA drive via sda_oe.
// All SDA drive changes are made in response to scl_fall so the line only
// moves while SCL is low.
module i2c_target_mem
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       busy,
   output logic       wr_strobe,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_data,
   output tgt_state_e dbg_state
);

   logic scl_rise, scl_fall, start_det, stop_det, sda_lvl;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_lvl   (sda_lvl)
   );

   tgt_state_e             state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [7:0]             sh_q, sh_d;
   logic [I2C_PTR_W-1:0]   ptr_q, ptr_d;
   logic                   sda_oe_q, sda_oe_d;
   logic                   busy_q, busy_d;
   logic                   wr_strobe_q, wr_strobe_d;
   logic [6:0]             wr_addr_q, wr_addr_d;
   logic [7:0]             wr_data_q, wr_data_d;
   logic [7:0]             mem_q [I2C_MEM_DEPTH];

   logic                   mem_we;
   logic [7:0]             mem_wdata;
   logic [I2C_PTR_W-1:0]   ptr_inc;
   logic [7:0]             rx_byte;
   logic                   take_bit;

   assign ptr_inc  = ptr_q + 7'd1;
   assign rx_byte  = {sh_q[6:0], sda_lvl};
   assign take_bit = scl_rise && (cnt_q < 4'd8);

   // Next-state, shift/count, pointer, SDA drive and write-port decisions.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      ptr_d       = ptr_q;
      sda_oe_d    = sda_oe_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      mem_we      = 1'b0;
      mem_wdata   = rx_byte;

      if (stop_det) begin
         state_d  = ST_IDLE;
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
      end else if (start_det) begin
         // START from idle and repeated START behave the same; ptr is kept.
         state_d  = ST_DEVADDR;
         cnt_d    = 4'd0;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
            end
            ST_DEVADDR: begin
               if (take_bit) begin
                  sh_d  = rx_byte;
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'd8) begin
                  if (sh_q[7:1] == DEV_ADDR) begin
                     state_d  = ST_ACK_DEV;
                     sda_oe_d = 1'b1;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
            ST_ACK_DEV: begin
               if (scl_fall) begin
                  cnt_d = 4'd0;
                  if (sh_q[0] == I2C_RW_READ) begin
                     state_d  = ST_RDATA;
                     sh_d     = mem_q[ptr_q];
                     sda_oe_d = ~mem_q[ptr_q][7];
                  end else begin
                     state_d  = ST_PTR;
                     sda_oe_d = 1'b0;
                  end
               end
            end
            ST_PTR: begin
               if (take_bit) begin
                  sh_d  = rx_byte;
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     ptr_d = rx_byte[6:0];
                  end
               end else if (scl_fall && cnt_q == 4'd8) begin
                  state_d  = ST_ACK_PTR;
                  sda_oe_d = 1'b1;
               end
            end
            ST_ACK_PTR, ST_ACK_W: begin
               if (scl_fall) begin
                  state_d  = ST_WDATA;
                  cnt_d    = 4'd0;
                  sda_oe_d = 1'b0;
               end
            end
            ST_WDATA: begin
               if (take_bit) begin
                  sh_d  = rx_byte;
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     mem_we      = 1'b1;
                     wr_strobe_d = 1'b1;
                     wr_addr_d   = ptr_q;
                     wr_data_d   = rx_byte;
                     ptr_d       = ptr_inc;
                  end
               end else if (scl_fall && cnt_q == 4'd8) begin
                  state_d  = ST_ACK_W;
                  sda_oe_d = 1'b1;
               end
            end
            ST_RDATA: begin
               if (take_bit) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     state_d  = ST_MACK;
                     sda_oe_d = 1'b0;
                  end else if (cnt_q == 4'd0) begin
                     // Byte loaded at the ACK rise: first bit goes out now.
                     sda_oe_d = ~sh_q[7];
                  end else begin
                     sh_d     = {sh_q[6:0], 1'b0};
                     sda_oe_d = ~sh_q[6];
                  end
               end
            end
            ST_MACK: begin
               if (scl_rise) begin
                  if (!sda_lvl) begin
                     state_d = ST_RDATA;
                     cnt_d   = 4'd0;
                     ptr_d   = ptr_inc;
                     sh_d    = mem_q[ptr_inc];
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
            ST_IGNORE: begin
            end
            default: begin
               state_d  = ST_IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end

      // busy follows the state we are entering.
      busy_d = busy_q;
      if (state_d == ST_ACK_DEV) begin
         busy_d = 1'b1;
      end else if (state_d == ST_IDLE || state_d == ST_IGNORE) begin
         busy_d = 1'b0;
      end
   end

   // State, datapath and memory registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         sh_q        <= 8'd0;
         ptr_q       <= '0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= 7'd0;
         wr_data_q   <= 8'd0;
         for (int i = 0; i < I2C_MEM_DEPTH; i++) begin
            mem_q[i] <= 8'd0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         ptr_q       <= ptr_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         if (mem_we) begin
            mem_q[ptr_q] <= mem_wdata;
         end
      end
   end

   assign sda_oe    = sda_oe_q;
   assign busy      = busy_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: a bit-level I2C master on open-drain lines, a
// byte-array memory model with a pointer, and a queue of expected writes.
module tb_i2c_target_mem;
   import i2c_pkg::*;

   localparam int PH = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_m, sda_m;
   logic       sda_line;
   logic       sda_oe, busy, wr_strobe;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;
   tgt_state_e dbg_state;

   assign sda_line = sda_m & ~sda_oe;

   i2c_target_mem #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (scl_m),
      .sda_i     (sda_line),
      .sda_oe    (sda_oe),
      .busy      (busy),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .dbg_state (dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   int          n_vec = 0;
   int          n_err = 0;
   logic [14:0] exp_q[$];
   logic [7:0]  mem_m [128];
   logic [6:0]  ptr_m;
   logic [7:0]  wbuf [8];
   logic        saw_oe, saw_busy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // write-port monitor against the expected queue
   always @(negedge clk) begin
      logic [14:0] e;
      if (sda_oe) saw_oe = 1'b1;
      if (busy) saw_busy = 1'b1;
      if (!rst && wr_strobe) begin
         if (exp_q.size() == 0) begin
            check("wr_unexp_strobe", 32'(wr_strobe), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e[14:8]));
            check("wr_data", 32'(wr_data), 32'(e[7:0]));
         end
      end
   end

   // master driver tasks (all activity on negedge)
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic m_bit(input logic b, output logic s);
      sda_m = b;
      tick(PH - 2);
      scl_m = 1'b1;
      tick(PH / 2);
      s = sda_line;
      tick(PH / 2);
      scl_m = 1'b0;
      tick(2);
   endtask

   task automatic m_start();
      sda_m = 1'b1;
      tick(PH - 2);
      scl_m = 1'b1;
      tick(PH);
      sda_m = 1'b0;
      tick(PH);
      scl_m = 1'b0;
      tick(2);
   endtask

   task automatic m_stop();
      sda_m = 1'b0;
      tick(PH - 2);
      scl_m = 1'b1;
      tick(PH);
      sda_m = 1'b1;
      tick(PH);
   endtask

   task automatic m_wbyte(input logic [7:0] b, output logic ack_lvl);
      logic s;
      for (int i = 7; i >= 0; i--) m_bit(b[i], s);
      m_bit(1'b1, ack_lvl);
   endtask

   task automatic m_rbyte(output logic [7:0] d, input logic nack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         m_bit(1'b1, s);
         d[i] = s;
      end
      m_bit(nack, s);
   endtask

   // write n bytes of wbuf starting at p; hi is the ignored pointer bit 7
   task automatic do_write(input logic [6:0] p, input int n, input logic hi);
      logic ack;
      m_start();
      m_wbyte(8'hA0, ack);
      check("w_dev_ack", 32'(ack), 32'd0);
      check("w_busy", 32'(busy), 32'd1);
      m_wbyte({hi, p}, ack);
      check("w_ptr_ack", 32'(ack), 32'd0);
      ptr_m = p;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({ptr_m, wbuf[i]});
         mem_m[ptr_m] = wbuf[i];
         ptr_m = ptr_m + 7'd1;
         m_wbyte(wbuf[i], ack);
         check("w_data_ack", 32'(ack), 32'd0);
      end
      m_stop();
      check("w_busy_after_stop", 32'(busy), 32'd0);
   endtask

   // read n bytes, ACK all but the last; cur=1 reads from the current pointer
   task automatic do_read(input logic [6:0] p, input int n, input logic cur);
      logic       ack;
      logic [7:0] d;
      if (!cur) begin
         m_start();
         m_wbyte(8'hA0, ack);
         check("r_dev_ack", 32'(ack), 32'd0);
         m_wbyte({1'b0, p}, ack);
         check("r_ptr_ack", 32'(ack), 32'd0);
         ptr_m = p;
      end
      m_start();
      m_wbyte(8'hA1, ack);
      check("r_devr_ack", 32'(ack), 32'd0);
      for (int i = 0; i < n; i++) begin
         m_rbyte(d, (i == n - 1));
         check("r_data", 32'(d), 32'(mem_m[ptr_m]));
         if (i < n - 1) ptr_m = ptr_m + 7'd1;
      end
      check("r_oe_after_nack", 32'(sda_oe), 32'd0);
      check("r_busy_after_nack", 32'(busy), 32'd0);
      m_stop();
   endtask

   // main sequence
   initial begin
      logic       ack, s, ok;
      int         n, mode;
      logic [6:0] p;

      rst = 1'b1;
      scl_m = 1'b1;
      sda_m = 1'b1;
      saw_oe = 1'b0;
      saw_busy = 1'b0;
      ptr_m = 7'd0;
      for (int i = 0; i < 128; i++) mem_m[i] = 8'd0;
      tick(5);
      rst = 1'b0;
      tick(5);

      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

      // current-address read straight after reset: ptr 0, memory 0
      do_read(7'd0, 1, 1'b1);

      // write at 0x10
      wbuf[0] = 8'hA5;
      wbuf[1] = 8'h3C;
      do_write(7'h10, 2, 1'b0);

      // random read back with repeated START
      do_read(7'h10, 2, 1'b0);

      // address mismatch: no ACK, not busy, memory untouched
      saw_oe = 1'b0;
      saw_busy = 1'b0;
      m_start();
      m_wbyte(8'hA2, ack);
      check("mm_dev_nack", 32'(ack), 32'd1);
      m_wbyte(8'h10, ack);
      check("mm_ptr_nack", 32'(ack), 32'd1);
      m_wbyte(8'hFF, ack);
      check("mm_data_nack", 32'(ack), 32'd1);
      m_stop();
      check("mm_saw_oe", 32'(saw_oe), 32'd0);
      check("mm_saw_busy", 32'(saw_busy), 32'd0);
      do_read(7'h10, 2, 1'b0);

      // pointer wrap
      wbuf[0] = 8'h11;
      wbuf[1] = 8'h22;
      do_write(7'h7F, 2, 1'b0);
      do_read(7'h7F, 2, 1'b0);

      // STOP after 5 data bits: no write, back to idle, next txn fine
      m_start();
      m_wbyte(8'hA0, ack);
      check("pb_dev_ack", 32'(ack), 32'd0);
      m_wbyte(8'h20, ack);
      check("pb_ptr_ack", 32'(ack), 32'd0);
      ptr_m = 7'h20;
      for (int i = 0; i < 5; i++) m_bit(1'b1, s);
      m_stop();
      check("pb_state_idle", 32'(dbg_state), 32'(ST_IDLE));
      check("pb_busy", 32'(busy), 32'd0);
      wbuf[0] = 8'h5A;
      do_write(7'h20, 1, 1'b0);
      do_read(7'h1F, 3, 1'b0);

      // randomized transactions
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(1, 4);
         p = (it % 3 == 0) ? 7'($urandom_range(124, 127)) : 7'($urandom_range(0, 127));
         for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
         do_write(p, n, 1'($urandom_range(0, 1)));
         mode = $urandom_range(0, 2);
         n = $urandom_range(1, 4);
         if (mode == 0) do_read(ptr_m, n, 1'b1);
         else if (mode == 1) do_read(p, n, 1'b0);
         else do_read(7'($urandom_range(0, 127)), n, 1'b0);
      end

      // reset in the middle of a read while the target holds SDA low
      wbuf[0] = 8'hA5;
      do_write(7'h10, 1, 1'b0);
      m_start();
      m_wbyte(8'hA0, ack);
      m_wbyte(8'h10, ack);
      m_start();
      m_wbyte(8'hA1, ack);
      check("rr_dev_ack", 32'(ack), 32'd0);
      m_bit(1'b1, s);
      check("rr_bit7", 32'(s), 32'(mem_m[7'h10][7]));
      ok = 1'b0;
      for (int i = 0; i < PH; i++) begin
         if (sda_oe) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      check("rr_oe_before_rst", 32'(ok), 32'd1);
      check("rr_busy_before_rst", 32'(busy), 32'd1);
      rst = 1'b1;
      tick(1);
      check("rr_oe_after_rst", 32'(sda_oe), 32'd0);
      check("rr_busy_after_rst", 32'(busy), 32'd0);
      check("rr_state_after_rst", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b0;
      for (int i = 0; i < 128; i++) mem_m[i] = 8'd0;
      ptr_m = 7'd0;
      exp_q.delete();
      tick(2);
      m_stop();
      do_read(7'h10, 1, 1'b0);

      tick(20);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
